multiplicador_seq: RTL and testbench



---
 rtl/multiplicador_seq.sv | 164 ++++++++++++++++
 tb/tb_multiplicador_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_seq.sv
// -----------------------------------------------------------------------------
// multiplicador_seq
//
// Iterative shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits. One
// partial product is accumulated per clock using a single WIDTH+1-bit adder.
// Replaces the combinational 8-bit multiplier in the ULA datapath. The
// start/busy/done handshake lets the ULA control FSM stall while a multiply
// is in flight.
//
// Timing: start is accepted on an IDLE edge. WIDTH CALC cycles follow, then
// one FIM cycle with done=1. busy covers CALC and FIM. One result is produced
// every WIDTH+2 cycles when start is reasserted in the IDLE cycle after FIM.
//
// Optional build macro: MULTIPLICADOR_SINAL_EN
//   Adds the signed_op input. When signed_op=1 the operands are two's
//   complement: their magnitudes are multiplied, and the result is negated
//   when the operand signs differ. Without the macro the port does not exist
//   and all arithmetic is unsigned.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   operation request, sampled only in IDLE
//   signed_op  in   (MULTIPLICADOR_SINAL_EN only) two's-complement operands
//   A          in   multiplicand, captured on the accepted start
//   B          in   multiplier, captured on the accepted start
//   P          out  product register; holds the last result
//   busy       out  high from the cycle after the accepted start through done
//   done       out  single-cycle pulse; P is valid from this cycle on
// -----------------------------------------------------------------------------
module multiplicador_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef MULTIPLICADOR_SINAL_EN
  input  logic               signed_op,
`endif
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIM  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mult_q,  mult_d;
  logic [WIDTH-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [2*WIDTH-1:0] p_q,     p_d;
  logic               neg_q,   neg_d;

  // Operand sign handling. Only magnitudes enter the shift-add core; the
  // sign of the result is remembered in neg_q.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef MULTIPLICADOR_SINAL_EN
  assign a_neg = signed_op & A[WIDTH-1];
  assign b_neg = signed_op & B[WIDTH-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  // -2^(WIDTH-1) negates to itself, which read as unsigned is exactly the
  // correct magnitude 2^(WIDTH-1), so no extra bit is needed.
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // One shift-add step: the upper half gains the multiplicand when the
  // current multiplier LSB is set (carry kept in bit WIDTH), then the whole
  // {acc, mult} pair shifts right by one.
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] step;

  assign sum  = mult_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};
  assign step = {sum[WIDTH:1], sum[0], mult_q[WIDTH-1:1]};

  // NOTE: every always_comb target gets its hold value first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    neg_d   = neg_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a_mag;
          mult_d  = b_mag;
          acc_d   = '0;
          cnt_d   = '0;
          neg_d   = a_neg ^ b_neg;
          state_d = CALC;
        end
      end

      CALC: begin
        acc_d = step[2*WIDTH-1:WIDTH];
        mult_d = step[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // The sign correction is folded into the load so that P already
          // holds the final value in the done cycle.
          p_d     = neg_q ? -step : step;
          state_d = FIM;
        end
      end

      FIM: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset as well, not only the FSM, so
      // an aborted operation leaves no stale partial product behind.
      state_q <= IDLE;
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      neg_q   <= neg_d;
    end
  end

  assign P    = p_q;
  assign busy = (state_q == CALC) || (state_q == FIM);
  assign done = (state_q == FIM);

endmodule

// File: tb/tb_multiplicador_seq.sv
// -----------------------------------------------------------------------------
// tb_multiplicador_seq
//
// Self-checking bench for multiplicador_seq (WIDTH=8). Directed scenarios
// plus randomized operands are compared against a plain-arithmetic reference
// product. Build with +define+MULTIPLICADOR_SINAL_EN to include the signed
// scenarios.
// -----------------------------------------------------------------------------
module tb_multiplicador_seq;

  localparam int W = 8;
  localparam int LAT = W + 1;  // cycles from the accepting edge to done

  logic           clk;
  logic           rst_n;
  logic           start;
`ifdef MULTIPLICADOR_SINAL_EN
  logic           signed_op;
`endif
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [2*W-1:0] P;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  multiplicador_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef MULTIPLICADOR_SINAL_EN
    .signed_op(signed_op),
`endif
    .A        (A),
    .B        (B),
    .P        (P),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product from ordinary integer arithmetic.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic s);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    longint prod;
    sa = a;
    sb = b;
    if (s) prod = longint'(sa) * longint'(sb);
    else   prod = longint'(a) * longint'(b);
    return prod[2*W-1:0];
  endfunction

  // Issues one operation from IDLE and watches a fixed window of cycles.
  // Called and returns at #1 after a rising edge. pulse_at / rst_at select a
  // window cycle in which start (with A=B=100) or reset is asserted for one
  // cycle; 0 disables them.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input int pulse_at, input int rst_at,
                        output logic [2*W-1:0] p_done, output int lat,
                        output int busy_cnt, output int dones);
    start = 1'b1;
    A = a;
    B = b;
`ifdef MULTIPLICADOR_SINAL_EN
    signed_op = s;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
`ifdef MULTIPLICADOR_SINAL_EN
    signed_op = 1'($urandom);
`endif
    lat = 0;
    busy_cnt = 0;
    dones = 0;
    p_done = '0;
    for (int k = 1; k <= W + 4; k++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        dones++;
        lat = k;
        p_done = P;
      end
      if (k == pulse_at) begin
        start = 1'b1;
        A = 8'd100;
        B = 8'd100;
      end else begin
        start = 1'b0;
      end
      rst_n = (k == rst_at) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    A = 8'hFF;
    B = 8'hFF;
`ifdef MULTIPLICADOR_SINAL_EN
    signed_op = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (P !== 16'h0000) begin
      errors++;
      $display("FAIL reset_P: got %h expected 0000", P);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed;
    logic [W-1:0]   ta [3];
    logic [W-1:0]   tb [3];
    logic [2*W-1:0] tp [3];
    logic [2*W-1:0] p;
    int lat, bc, dn;
    ta = '{8'd13, 8'd255, 8'd0};
    tb = '{8'd11, 8'd255, 8'd200};
    tp = '{16'h008F, 16'hFE01, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      do_mul(ta[i], tb[i], 1'b0, 0, 0, p, lat, bc, dn);
      checks++;
      if (p !== tp[i]) begin
        errors++;
        $display("FAIL directed_P[%0d]: got %h expected %h", i, p, tp[i]);
      end
      checks++;
      if (lat !== LAT || dn !== 1) begin
        errors++;
        $display("FAIL directed_done[%0d]: latency %0d pulses %0d expected %0d and 1",
                 i, lat, dn, LAT);
      end
      checks++;
      if (bc !== LAT) begin
        errors++;
        $display("FAIL directed_busy[%0d]: busy cycles %0d expected %0d", i, bc, LAT);
      end
      // Window ends three cycles into IDLE: result must still be held.
      checks++;
      if (P !== tp[i] || busy !== 1'b0) begin
        errors++;
        $display("FAIL directed_hold[%0d]: P %h busy %b expected %h and 0",
                 i, P, busy, tp[i]);
      end
    end
  endtask

  task automatic test_start_while_busy;
    logic [2*W-1:0] p;
    int lat, bc, dn;
    do_mul(8'd7, 8'd6, 1'b0, 3, 0, p, lat, bc, dn);
    checks++;
    if (p !== 16'd42 || P !== 16'd42) begin
      errors++;
      $display("FAIL busy_start_P: got %h/%h expected %h", p, P, 16'd42);
    end
    checks++;
    if (dn !== 1 || lat !== LAT || bc !== LAT || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_pulses: pulses %0d latency %0d busy %0d/%b expected 1 %0d %0d/0",
               dn, lat, bc, busy, LAT, LAT);
    end
  endtask

  task automatic test_reset_abort;
    logic [2*W-1:0] p;
    int lat, bc, dn;
    do_mul(8'd50, 8'd3, 1'b0, 0, 4, p, lat, bc, dn);
    checks++;
    if (dn !== 0 || P !== 16'h0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: pulses %0d P %h busy %b expected 0 0000 0", dn, P, busy);
    end
    do_mul(8'd2, 8'd3, 1'b0, 0, 0, p, lat, bc, dn);
    checks++;
    if (p !== 16'd6 || dn !== 1 || lat !== LAT) begin
      errors++;
      $display("FAIL after_abort: P %h pulses %0d latency %0d expected 0006 1 %0d",
               p, dn, lat, LAT);
    end
  endtask

  task automatic test_back_to_back;
    logic [2*W-1:0] p;
    int lat, bc, dn, gap;
    bit early;
    do_mul(8'd9, 8'd7, 1'b0, 0, 0, p, lat, bc, dn);
    // Restart the first operation and keep start high from its FIM cycle on:
    // the FIM edge must ignore it, the following IDLE edge must accept it.
    start = 1'b1;
    A = 8'd9;
    B = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    gap = 0;
    for (int k = 1; k <= W + 4 && gap == 0; k++) begin
      if (done === 1'b1) gap = k;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (gap !== LAT || P !== 16'd63) begin
      errors++;
      $display("FAIL b2b_first: latency %0d P %h expected %0d 003F", gap, P, LAT);
    end
    start = 1'b1;
    A = 8'd20;
    B = 8'd20;
    @(posedge clk);  // FIM -> IDLE
    #1;
    checks++;
    if (busy !== 1'b0 || P !== 16'd63) begin
      errors++;
      $display("FAIL b2b_idle: busy %b P %h expected 0 003F", busy, P);
    end
    @(posedge clk);  // accepting edge
    #1;
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    gap = 0;
    early = 1'b0;
    for (int k = 1; k <= W + 4 && gap == 0; k++) begin
      if (done === 1'b1) begin
        gap = k;
        p = P;
      end else begin
        if (P !== 16'd63) early = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (gap !== LAT || p !== 16'd400 || early) begin
      errors++;
      $display("FAIL b2b_second: latency %0d P %h early_change %b expected %0d 0190 0",
               gap, p, early, LAT);
    end
    // Leave the DUT in IDLE for the next scenario.
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    logic [W-1:0]   a, b;
    logic           s;
    logic [2*W-1:0] p, exp_p;
    int lat, bc, dn;
    for (int i = 0; i < 16; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i == 0) a = '0;
      if (i == 1) b = '1;
`ifdef MULTIPLICADOR_SINAL_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      exp_p = ref_mul(a, b, s);
      do_mul(a, b, s, 0, 0, p, lat, bc, dn);
      checks++;
      if (p !== exp_p || dn !== 1 || lat !== LAT) begin
        errors++;
        $display("FAIL random[%0d] %h*%h s=%b: P %h pulses %0d latency %0d expected %h 1 %0d",
                 i, a, b, s, p, dn, lat, exp_p, LAT);
      end
    end
  endtask

`ifdef MULTIPLICADOR_SINAL_EN
  task automatic test_signed;
    logic [W-1:0]   ta [4];
    logic [W-1:0]   tb [4];
    logic           ts [4];
    logic [2*W-1:0] tp [4];
    logic [2*W-1:0] p;
    int lat, bc, dn;
    ta = '{8'hFD, 8'h80, 8'hFD, 8'h7F};
    tb = '{8'h05, 8'h80, 8'h05, 8'h80};
    ts = '{1'b1, 1'b1, 1'b0, 1'b1};
    tp = '{16'hFFF1, 16'h4000, 16'h04F1, 16'hC080};
    for (int i = 0; i < 4; i++) begin
      do_mul(ta[i], tb[i], ts[i], 0, 0, p, lat, bc, dn);
      checks++;
      if (p !== tp[i] || dn !== 1 || lat !== LAT) begin
        errors++;
        $display("FAIL signed[%0d]: P %h pulses %0d latency %0d expected %h 1 %0d",
                 i, p, dn, lat, tp[i], LAT);
      end
    end
  endtask
`endif

  initial begin
    start = 1'b0;
    rst_n = 1'b0;
    A = '0;
    B = '0;
`ifdef MULTIPLICADOR_SINAL_EN
    signed_op = 1'b0;
`endif
    @(posedge clk);
    #1;
    test_reset;
    test_directed;
    test_start_while_busy;
    test_reset_abort;
    test_back_to_back;
    test_random;
`ifdef MULTIPLICADOR_SINAL_EN
    test_signed;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
